multi_buffer_controller: RTL and testbench
==========================================

# multi_buffer_controller

Parametrised N-buffer frame-store arbiter between the camera write path and the display read path, sitting in front of the SDRAM framebuffer. It generalises the fixed triple-buffer controller to NUM_BUFFERS slots with two selectable policies: "latest" (stale frames dropped) and "queue" (FIFO order with writer backpressure). It hands out buffer indices through level-request / valid-grant / finalize handshakes. It also reports dropped and repeated frames.

## Interface
- NUM_BUFFERS, 3, number of frame slots, ≥3
- ID_WIDTH, $clog2(NUM_BUFFERS), width of buffer indices
- MODE, 0, 0 = latest, 1 = queue
- LOG_LEVEL, `SVL_VERBOSE_INFO`, simulation logging verbosity only

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- write_rq_rdy  in  1  writer requests a buffer (level)
- finalize_wr  in  1  single-cycle pulse: writer finished the current buffer
- read_rq_rdy  in  1  reader requests a buffer (level)
- finalize_rd  in  1  single-cycle pulse: reader finished the current buffer
- wr_id_valid  out  1  wr_id is a granted write buffer
- wr_id  out  ID_WIDTH  write buffer index
- rd_id_valid  out  1  rd_id is a granted read buffer
- rd_id  out  ID_WIDTH  read buffer index
- frame_dropped  out  1  one-cycle pulse: a READY frame was discarded unread
- frame_repeated  out  1  one-cycle pulse: reader re-granted the HELD frame
- ready_count  out  $clog2(NUM_BUFFERS+1)  number of READY slots

## Operation
- Per-slot state: FREE, WRITING, READY, READING, HELD. A READY-order list (oldest first) is kept for queue mode.
- Reset state:
  - slot 0 is READY (blank initial frame); all other slots are FREE
  - wr_ptr = 1, rd FSM idle
  - all outputs 0, except ready_count = 1
- Write FSM, W_IDLE → W_SEARCH → W_GRANT → W_ACTIVE → W_IDLE:
  - W_IDLE: move to W_SEARCH when write_rq_rdy = 1.
  - W_SEARCH: pick the first FREE slot scanning round-robin from wr_ptr. Mark it WRITING, register wr_id, set wr_ptr = id+1 mod N, go to W_GRANT.
  - W_SEARCH with no FREE slot (queue mode only): stay in W_SEARCH and rescan each cycle.
  - W_GRANT: wr_id_valid = 1. Go to W_ACTIVE when write_rq_rdy = 0.
  - W_ACTIVE: on finalize_wr, the slot becomes READY; go to W_IDLE.
  - finalize_wr in W_GRANT: also accepted; the slot becomes READY and the FSM goes to W_IDLE.
- Commit, latest mode: any other READY slot becomes FREE and frame_dropped pulses. ready_count stays ≤1.
- Commit, queue mode: the slot is appended to the READY list and nothing is dropped.
- Read FSM, R_IDLE → R_SEARCH → R_GRANT → R_ACTIVE → R_IDLE, with the same handshake as the write FSM:
  - R_SEARCH, latest mode: select the single READY slot.
  - R_SEARCH, queue mode: select the oldest READY slot.
  - On selection, the slot becomes READING and any HELD slot becomes FREE.
  - No READY slot but a HELD slot exists: re-grant the HELD slot as READING and pulse frame_repeated.
  - Neither READY nor HELD: wait in R_SEARCH.
  - finalize_rd: the READING slot becomes HELD.
- finalize_wr / finalize_rd with no active grant: ignored.
- Asserting a request while a grant is active has no effect until the FSM returns to IDLE.

## Timing
- Grant latency: request sampled high at edge k → valid high after edge k+2, provided a slot is available.
- Valid deassert: valid drops on the edge after the request is sampled low.
- wr_id / rd_id: stable while valid = 1; hold their last value otherwise.
- Same-edge finalize_wr commit and read R_SEARCH: the commit is applied first, so the reader sees the new frame.
- Same-edge finalize_wr and finalize_rd: both are applied; the states they touch are disjoint.
- frame_dropped / frame_repeated: exactly one cycle, registered, coincident with the state update.
- ready_count: updated on the same edge as the state change.
- reset asserted mid-operation: on the next edge all FSMs and slots return to the reset state and all pulses clear.

## Test plan
- Writes only, N=3, latest mode, 10 write/finalize cycles:
  - grants are 1,2,0,1,2,0,1,2,0,1
  - valid is low one cycle after write_rq_rdy drops
  - frame_dropped pulses on each finalize
  - ready_count stays 1
- Reads only after reset:
  - first rd_id = 0 with no repeat pulse
  - second read → rd_id = 0 with frame_repeated = 1
- Queue mode, N=4, writes only:
  - grants are 1,2,3
  - the 4th request leaves wr_id_valid low indefinitely; ready_count = 4
  - one read (rd_id = 0) then finalize_rd, then another read (rd_id = 1) → slot 0 FREE and the pending write grants 0
- Same-cycle finalize_wr (slot 1) and read search, latest mode → rd_id = 1, frame_dropped = 1 for slot 0.
- Reset asserted while W_GRANT and R_ACTIVE → next cycle all outputs 0, ready_count = 1, and the next write grants 1.

Source files
------------

// File: rtl/multi_buffer_controller_if.sv
// Handshake bundle between the frame-store arbiter and its camera/display clients.
interface multi_buffer_controller_if #(
   parameter int NUM_BUFFERS = 3
);
   localparam int ID_WIDTH  = $clog2(NUM_BUFFERS);
   localparam int CNT_WIDTH = $clog2(NUM_BUFFERS + 1);

   logic                 write_rq_rdy;
   logic                 finalize_wr;
   logic                 read_rq_rdy;
   logic                 finalize_rd;
   logic                 wr_id_valid;
   logic [ID_WIDTH-1:0]  wr_id;
   logic                 rd_id_valid;
   logic [ID_WIDTH-1:0]  rd_id;
   logic                 frame_dropped;
   logic                 frame_repeated;
   logic [CNT_WIDTH-1:0] ready_count;

   // Clients: camera writer and display reader
   modport master (
      output write_rq_rdy, finalize_wr, read_rq_rdy, finalize_rd,
      input  wr_id_valid, wr_id, rd_id_valid, rd_id,
             frame_dropped, frame_repeated, ready_count
   );

   // Arbiter side
   modport slave (
      input  write_rq_rdy, finalize_wr, read_rq_rdy, finalize_rd,
      output wr_id_valid, wr_id, rd_id_valid, rd_id,
             frame_dropped, frame_repeated, ready_count
   );
endinterface

// File: rtl/multi_buffer_controller.sv
// N-slot frame-store arbiter: hands out write/read buffer indices, with
// "latest" (drop stale frames) or "queue" (FIFO with writer backpressure) policy.
`ifndef SVL_VERBOSE_INFO
`define SVL_VERBOSE_INFO 3
`endif

module multi_buffer_controller #(
   parameter int NUM_BUFFERS = 3,
   parameter int ID_WIDTH    = $clog2(NUM_BUFFERS),
   parameter int MODE        = 0,
   parameter int LOG_LEVEL   = `SVL_VERBOSE_INFO
) (
   input  logic                      clk,
   input  logic                      reset,
   multi_buffer_controller_if.slave  bus
);
   localparam int CW = $clog2(NUM_BUFFERS + 1);

   typedef enum logic [2:0] {S_FREE, S_WRITING, S_READY, S_READING, S_HELD} slot_t;
   typedef enum logic [1:0] {W_IDLE, W_SEARCH, W_GRANT, W_ACTIVE} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_SEARCH, R_GRANT, R_ACTIVE} rd_state_t;

   slot_t               slot_q  [NUM_BUFFERS];
   slot_t               slot_d  [NUM_BUFFERS];
   logic [ID_WIDTH-1:0] order_q [NUM_BUFFERS];
   logic [ID_WIDTH-1:0] order_c [NUM_BUFFERS];
   logic [ID_WIDTH-1:0] order_d [NUM_BUFFERS];
   logic [CW-1:0]       cnt_q, cnt_c, cnt_d;

   wr_state_t           wr_state;
   rd_state_t           rd_state;
   logic [ID_WIDTH-1:0] wr_ptr;
   logic [ID_WIDTH-1:0] wr_id_q, rd_id_q;
   logic                wr_valid_q, rd_valid_q;
   logic                dropped_q, repeated_q;

   logic                wr_commit, rd_finish;
   logic                wr_found;
   logic [ID_WIDTH-1:0] wr_pick, cand;
   logic                held_found;
   logic [ID_WIDTH-1:0] held_idx;
   logic                rd_take, rd_repeat;
   logic [ID_WIDTH-1:0] rd_pick;
   logic                drop;

   assign bus.wr_id_valid    = wr_valid_q;
   assign bus.wr_id          = wr_id_q;
   assign bus.rd_id_valid    = rd_valid_q;
   assign bus.rd_id          = rd_id_q;
   assign bus.frame_dropped  = dropped_q;
   assign bus.frame_repeated = repeated_q;
   assign bus.ready_count    = cnt_q;

   // Free-slot search (round-robin from wr_ptr) and HELD-slot lookup
   always_comb begin
      wr_found   = 1'b0;
      wr_pick    = '0;
      cand       = '0;
      held_found = 1'b0;
      held_idx   = '0;
      for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
         cand = ID_WIDTH'((32'(wr_ptr) + i) % NUM_BUFFERS);
         if (!wr_found && slot_q[cand] == S_FREE) begin
            wr_found = 1'b1;
            wr_pick  = cand;
         end
         if (slot_q[i] == S_HELD) begin
            held_found = 1'b1;
            held_idx   = ID_WIDTH'(i);
         end
      end
   end

   // READY-order list: writer commit is applied before the reader pops,
   // so a same-edge read search sees the frame just committed
   always_comb begin
      wr_commit = bus.finalize_wr && (wr_state == W_GRANT || wr_state == W_ACTIVE);
      rd_finish = bus.finalize_rd && (rd_state == R_GRANT || rd_state == R_ACTIVE);
      order_c   = order_q;
      cnt_c     = cnt_q;
      drop      = 1'b0;
      if (wr_commit) begin
         if (MODE == 0) begin
            drop       = (cnt_q != '0);
            order_c[0] = wr_id_q;
            cnt_c      = CW'(1);
         end else begin
            order_c[ID_WIDTH'(cnt_q)] = wr_id_q;
            cnt_c = cnt_q + CW'(1);
         end
      end
      order_d   = order_c;
      cnt_d     = cnt_c;
      rd_take   = 1'b0;
      rd_repeat = 1'b0;
      rd_pick   = '0;
      if (rd_state == R_SEARCH) begin
         if (cnt_c != '0) begin
            rd_take = 1'b1;
            rd_pick = order_c[0];
            for (int unsigned i = 0; i + 1 < NUM_BUFFERS; i++)
               order_d[i] = order_c[i+1];
            cnt_d = cnt_c - CW'(1);
         end else if (held_found) begin
            rd_repeat = 1'b1;
            rd_pick   = held_idx;
         end
      end
   end

   // Per-slot state transitions from both FSMs (they touch disjoint slots)
   always_comb begin
      slot_d = slot_q;
      if (wr_state == W_SEARCH && wr_found)
         slot_d[wr_pick] = S_WRITING;
      if (wr_commit) begin
         if (MODE == 0)
            for (int unsigned i = 0; i < NUM_BUFFERS; i++)
               if (slot_q[i] == S_READY) slot_d[i] = S_FREE;
         slot_d[wr_id_q] = S_READY;
      end
      if (rd_finish)
         slot_d[rd_id_q] = S_HELD;
      if (rd_take) begin
         for (int unsigned i = 0; i < NUM_BUFFERS; i++)
            if (slot_q[i] == S_HELD) slot_d[i] = S_FREE;
         slot_d[rd_pick] = S_READING;
      end
      if (rd_repeat)
         slot_d[held_idx] = S_READING;
   end

   // Write/read handshake FSMs plus registered slot table and status pulses;
   // valid rises one cycle after entering GRANT, giving request-to-valid of two edges
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
            slot_q[i]  <= (i == 0) ? S_READY : S_FREE;
            order_q[i] <= '0;
         end
         cnt_q      <= CW'(1);
         wr_ptr     <= ID_WIDTH'(1);
         wr_state   <= W_IDLE;
         rd_state   <= R_IDLE;
         wr_id_q    <= '0;
         rd_id_q    <= '0;
         wr_valid_q <= 1'b0;
         rd_valid_q <= 1'b0;
         dropped_q  <= 1'b0;
         repeated_q <= 1'b0;
      end else begin
         slot_q     <= slot_d;
         order_q    <= order_d;
         cnt_q      <= cnt_d;
         dropped_q  <= drop;
         repeated_q <= rd_repeat;

         case (wr_state)
            W_IDLE:   if (bus.write_rq_rdy) wr_state <= W_SEARCH;
            W_SEARCH: if (wr_found) begin
                         wr_id_q  <= wr_pick;
                         wr_ptr   <= ID_WIDTH'((32'(wr_pick) + 1) % NUM_BUFFERS);
                         wr_state <= W_GRANT;
                      end
            W_GRANT:  if (bus.finalize_wr) begin
                         wr_valid_q <= 1'b0;
                         wr_state   <= W_IDLE;
                      end else if (!bus.write_rq_rdy) begin
                         wr_valid_q <= 1'b0;
                         wr_state   <= W_ACTIVE;
                      end else begin
                         wr_valid_q <= 1'b1;
                      end
            W_ACTIVE: if (bus.finalize_wr) wr_state <= W_IDLE;
            default:  wr_state <= W_IDLE;
         endcase

         case (rd_state)
            R_IDLE:   if (bus.read_rq_rdy) rd_state <= R_SEARCH;
            R_SEARCH: if (rd_take || rd_repeat) begin
                         rd_id_q  <= rd_pick;
                         rd_state <= R_GRANT;
                      end
            R_GRANT:  if (bus.finalize_rd) begin
                         rd_valid_q <= 1'b0;
                         rd_state   <= R_IDLE;
                      end else if (!bus.read_rq_rdy) begin
                         rd_valid_q <= 1'b0;
                         rd_state   <= R_ACTIVE;
                      end else begin
                         rd_valid_q <= 1'b1;
                      end
            R_ACTIVE: if (bus.finalize_rd) rd_state <= R_IDLE;
            default:  rd_state <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_multi_buffer_controller.sv
// Directed bench: latest-mode DUT (N=3) and queue-mode DUT (N=4) with hand-computed expectations.
module tb_multi_buffer_controller;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_miss = 0;

   multi_buffer_controller_if #(.NUM_BUFFERS(3)) bus_l ();
   multi_buffer_controller_if #(.NUM_BUFFERS(4)) bus_q ();

   multi_buffer_controller #(.NUM_BUFFERS(3), .MODE(0)) dut_latest (
      .clk(clk), .reset(reset), .bus(bus_l));
   multi_buffer_controller #(.NUM_BUFFERS(4), .MODE(1)) dut_queue (
      .clk(clk), .reset(reset), .bus(bus_q));

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   initial begin
      int exp_id;
      bus_l.write_rq_rdy = 0; bus_l.finalize_wr = 0;
      bus_l.read_rq_rdy  = 0; bus_l.finalize_rd = 0;
      bus_q.write_rq_rdy = 0; bus_q.finalize_wr = 0;
      bus_q.read_rq_rdy  = 0; bus_q.finalize_rd = 0;
      do_reset();

      // reset state
      check("rst_wr_valid", 32'(bus_l.wr_id_valid), 0);
      check("rst_wr_id", 32'(bus_l.wr_id), 0);
      check("rst_rd_valid", 32'(bus_l.rd_id_valid), 0);
      check("rst_rd_id", 32'(bus_l.rd_id), 0);
      check("rst_dropped", 32'(bus_l.frame_dropped), 0);
      check("rst_repeated", 32'(bus_l.frame_repeated), 0);
      check("rst_ready_cnt", 32'(bus_l.ready_count), 1);
      check("rst_q_ready_cnt", 32'(bus_q.ready_count), 1);

      // latest mode, writes only: round-robin grants, every commit drops
      for (int k = 0; k < 10; k++) begin
         exp_id = (k % 3 + 1) % 3;
         bus_l.write_rq_rdy = 1;
         step(2);
         if (k == 0) check("wr_latency_early", 32'(bus_l.wr_id_valid), 0);
         step(1);
         check("wr_valid", 32'(bus_l.wr_id_valid), 1);
         check("wr_id", 32'(bus_l.wr_id), 32'(exp_id));
         bus_l.write_rq_rdy = 0;
         step(1);
         check("wr_valid_drop", 32'(bus_l.wr_id_valid), 0);
         bus_l.finalize_wr = 1;
         step(1);
         bus_l.finalize_wr = 0;
         check("wr_dropped", 32'(bus_l.frame_dropped), 1);
         check("wr_ready_cnt", 32'(bus_l.ready_count), 1);
         step(1);
         check("wr_dropped_pulse", 32'(bus_l.frame_dropped), 0);
      end

      // reads only: blank frame, then the HELD frame is repeated
      do_reset();
      for (int k = 0; k < 2; k++) begin
         bus_l.read_rq_rdy = 1;
         step(2);
         check("rd_repeated", 32'(bus_l.frame_repeated), 32'(k));
         step(1);
         check("rd_valid", 32'(bus_l.rd_id_valid), 1);
         check("rd_id", 32'(bus_l.rd_id), 0);
         check("rd_ready_cnt", 32'(bus_l.ready_count), 0);
         bus_l.read_rq_rdy = 0;
         step(1);
         check("rd_valid_drop", 32'(bus_l.rd_id_valid), 0);
         bus_l.finalize_rd = 1;
         step(1);
         bus_l.finalize_rd = 0;
         step(1);
      end

      // same-edge commit of slot 1 and read search
      do_reset();
      bus_l.write_rq_rdy = 1;
      step(3);
      check("same_wr_id", 32'(bus_l.wr_id), 1);
      bus_l.write_rq_rdy = 0;
      step(1);
      bus_l.read_rq_rdy = 1;
      step(1);
      bus_l.finalize_wr = 1;
      step(1);
      bus_l.finalize_wr = 0;
      check("same_dropped", 32'(bus_l.frame_dropped), 1);
      check("same_ready_cnt", 32'(bus_l.ready_count), 0);
      step(1);
      check("same_rd_valid", 32'(bus_l.rd_id_valid), 1);
      check("same_rd_id", 32'(bus_l.rd_id), 1);
      bus_l.read_rq_rdy = 0;
      step(1);
      bus_l.finalize_rd = 1;
      step(1);
      bus_l.finalize_rd = 0;

      // reset while writer in GRANT and reader in ACTIVE
      do_reset();
      bus_l.write_rq_rdy = 1;
      step(3);
      bus_l.read_rq_rdy = 1;
      step(3);
      check("mid_rd_valid", 32'(bus_l.rd_id_valid), 1);
      bus_l.read_rq_rdy = 0;
      step(1);
      check("mid_wr_valid", 32'(bus_l.wr_id_valid), 1);
      check("mid_wr_id", 32'(bus_l.wr_id), 1);
      bus_l.write_rq_rdy = 0;
      reset = 1'b1;
      step(1);
      check("mid_rst_wr_valid", 32'(bus_l.wr_id_valid), 0);
      check("mid_rst_wr_id", 32'(bus_l.wr_id), 0);
      check("mid_rst_rd_valid", 32'(bus_l.rd_id_valid), 0);
      check("mid_rst_ready_cnt", 32'(bus_l.ready_count), 1);
      reset = 1'b0;
      bus_l.write_rq_rdy = 1;
      step(3);
      check("mid_next_wr_id", 32'(bus_l.wr_id), 1);
      check("mid_next_wr_valid", 32'(bus_l.wr_id_valid), 1);
      bus_l.write_rq_rdy = 0;
      step(1);

      // queue mode, N=4: fill all slots, then backpressure
      do_reset();
      for (int k = 0; k < 3; k++) begin
         bus_q.write_rq_rdy = 1;
         step(3);
         check("q_wr_valid", 32'(bus_q.wr_id_valid), 1);
         check("q_wr_id", 32'(bus_q.wr_id), 32'(k + 1));
         bus_q.write_rq_rdy = 0;
         step(1);
         bus_q.finalize_wr = 1;
         step(1);
         bus_q.finalize_wr = 0;
         check("q_no_drop", 32'(bus_q.frame_dropped), 0);
      end
      check("q_ready_cnt_full", 32'(bus_q.ready_count), 4);
      bus_q.write_rq_rdy = 1;
      step(10);
      check("q_wr_blocked", 32'(bus_q.wr_id_valid), 0);

      bus_q.read_rq_rdy = 1;
      step(3);
      check("q_rd1_valid", 32'(bus_q.rd_id_valid), 1);
      check("q_rd1_id", 32'(bus_q.rd_id), 0);
      bus_q.read_rq_rdy = 0;
      step(1);
      bus_q.finalize_rd = 1;
      step(1);
      bus_q.finalize_rd = 0;
      check("q_wr_still_blocked", 32'(bus_q.wr_id_valid), 0);

      bus_q.read_rq_rdy = 1;
      step(3);
      check("q_rd2_id", 32'(bus_q.rd_id), 1);
      check("q_ready_cnt_after", 32'(bus_q.ready_count), 2);
      for (int c = 0; c < 10 && !bus_q.wr_id_valid; c++) step(1);
      check("q_wr_unblocked", 32'(bus_q.wr_id_valid), 1);
      check("q_wr_id_reused", 32'(bus_q.wr_id), 0);
      bus_q.read_rq_rdy = 0;
      bus_q.write_rq_rdy = 0;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
